// File: rtl/iir_mult_sched.sv
// iir_mult_sched: round-robin sharing of one pipelined signed multiplier
// between NUM_CH first-order IIR channels. A registered grant drives the
// multiplier operands, a channel-tag pipeline follows each product through
// the multiplier, and the scaled, saturated result goes back to its owner
// with a one-cycle strobe.
module iir_mult_sched #(
    parameter int NUM_CH   = 4,
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int MULT_LAT = 2,
    parameter int SHIFT    = 6,
    parameter int OUT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_CH-1:0]             req,
    input  logic [NUM_CH*A_W-1:0]         a_flat,
    input  logic [NUM_CH*B_W-1:0]         b_flat,
    output logic [NUM_CH-1:0]             grant,
    output logic [A_W-1:0]                mult_a,
    output logic [B_W-1:0]                mult_b,
    input  logic [A_W+B_W-1:0]            mult_p,
    output logic                          res_valid,
    output logic [$clog2(NUM_CH)-1:0]     res_ch,
    output logic [OUT_W-1:0]              res_data,
    output logic                          res_sat,
    output logic                          busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int P_W  = A_W + B_W;
    localparam int TAGS = MULT_LAT + 1;

    // Saturation limits expressed at product width so the shifted product
    // can be compared directly; the minimum is the bitwise inverse of the
    // maximum in two's complement.
    localparam logic signed [P_W-1:0] RES_MAX = P_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [P_W-1:0] RES_MIN = ~RES_MAX;
    localparam logic [OUT_W-1:0]      OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]      OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Per-channel operand views of the flattened input buses.
    logic [A_W-1:0] a_arr [NUM_CH];
    logic [B_W-1:0] b_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign a_arr[gi] = a_flat[gi*A_W +: A_W];
            assign b_arr[gi] = b_flat[gi*B_W +: B_W];
        end
    endgenerate

    // Arbitration state: the last winner sets the starting point of the scan.
    logic [CH_W-1:0]   last_reg;
    logic [NUM_CH-1:0] eligible;
    logic [CH_W:0]     cand;
    logic              win_found;
    logic              win_valid;
    logic [CH_W-1:0]   win_ch;
    logic [NUM_CH-1:0] grant_next;

    // Tag pipeline: stage k holds the owner of the product k edges after its
    // grant; the last stage lines up with mult_p being valid.
    logic [TAGS-1:0] tag_valid_reg;
    logic [CH_W-1:0] tag_ch_reg [TAGS];

    // Result arithmetic on the product currently at the multiplier output.
    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] shifted;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_W-1:0]      sat_data;

    // Round-robin scan starting one past the last winner. The channel
    // granted in the current cycle is masked so a requester that is late
    // dropping req is not granted twice back to back.
    always_comb begin
        eligible  = req & ~grant;
        cand      = '0;
        win_found = 1'b0;
        win_ch    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, last_reg} + (CH_W + 1)'(i);
            if (cand >= (CH_W + 1)'(NUM_CH)) begin
                cand = cand - (CH_W + 1)'(NUM_CH);
            end
            if (!win_found && eligible[cand[CH_W-1:0]]) begin
                win_found = 1'b1;
                win_ch    = cand[CH_W-1:0];
            end
        end
        win_valid  = en && win_found;
        grant_next = '0;
        if (win_valid) begin
            grant_next[win_ch] = 1'b1;
        end
    end

    // Grant register, operand registers and round-robin pointer. Operands
    // hold when nothing is granted so the multiplier inputs stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant    <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            last_reg <= CH_W'(NUM_CH - 1);
        end else begin
            grant <= grant_next;
            if (win_valid) begin
                mult_a   <= a_arr[win_ch];
                mult_b   <= b_arr[win_ch];
                last_reg <= win_ch;
            end
        end
    end

    // Shift the owner tag alongside the product; a cycle without a grant
    // pushes a bubble. Reset clears every tag so stale products are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid_reg <= '0;
            for (int k = 0; k < TAGS; k++) begin
                tag_ch_reg[k] <= '0;
            end
        end else begin
            tag_valid_reg[0] <= win_valid;
            tag_ch_reg[0]    <= win_ch;
            for (int k = 1; k < TAGS; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_ch_reg[k]    <= tag_ch_reg[k-1];
            end
        end
    end

    assign busy = |tag_valid_reg;

    // Floor-scale the product and clip it into the output range.
    always_comb begin
        prod_s  = $signed(mult_p);
        shifted = prod_s >>> SHIFT;
        sat_hi  = (shifted > RES_MAX);
        sat_lo  = (shifted < RES_MIN);
        if (sat_hi) begin
            sat_data = OUT_MAX;
        end else if (sat_lo) begin
            sat_data = OUT_MIN;
        end else begin
            sat_data = shifted[OUT_W-1:0];
        end
    end

    // Result register: data and channel hold between strobes, the
    // saturation flag is only meaningful alongside res_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else begin
            res_valid <= tag_valid_reg[TAGS-1];
            res_sat   <= tag_valid_reg[TAGS-1] && (sat_hi || sat_lo);
            if (tag_valid_reg[TAGS-1]) begin
                res_ch   <= tag_ch_reg[TAGS-1];
                res_data <= sat_data;
            end
        end
    end

endmodule

// File: tb/tb_iir_mult_sched.sv
// Testbench for iir_mult_sched: table of single-channel transactions with
// hand-computed results, followed by directed sequences for fairness,
// masking, reset in flight and enable gating. Includes a two-stage
// registered multiplier model feeding mult_p.
module tb_iir_mult_sched;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic [3:0]  grant;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic [15:0] mult_p;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [7:0]  res_data;
    logic        res_sat;
    logic        busy;

    int n_cmp;
    int n_bad;

    iir_mult_sched #(
        .NUM_CH(4), .A_W(8), .B_W(8), .MULT_LAT(2), .SHIFT(6), .OUT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .a_flat(a_flat), .b_flat(b_flat), .grant(grant),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .res_sat(res_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product valid two edges after operands register.
    logic signed [15:0] p_pipe [2];
    always @(posedge clk) begin
        p_pipe[0] <= $signed(mult_a) * $signed(mult_b);
        p_pipe[1] <= p_pipe[0];
    end
    assign mult_p = p_pipe[1];

    typedef struct {
        int               ch;
        logic signed [7:0] a;
        logic signed [7:0] b;
        int               exp_d;
        bit               exp_s;
    } vec_t;

    vec_t vecs [10];

    // Fairness operands and their hand-computed results.
    int fa_a [4];
    int fa_b [4];
    int fa_d [4];
    int fa_s [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int ch, input logic [7:0] a, input logic [7:0] b);
        a_flat[ch*8 +: 8] = a;
        b_flat[ch*8 +: 8] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        en     = 1'b0;
        req    = '0;
        a_flat = '0;
        b_flat = '0;

        vecs[0] = '{2,   8'sd64, -8'sd100, -100, 1'b0};
        vecs[1] = '{0,  8'sd127,  8'sd127,  127, 1'b1};
        vecs[2] = '{0, -8'sd128,  8'sd127, -128, 1'b1};
        vecs[3] = '{0,    8'sd1,   -8'sd1,   -1, 1'b0};
        vecs[4] = '{1, -8'sd128, -8'sd128,  127, 1'b1};
        vecs[5] = '{3,  8'sd100,   8'sd50,   78, 1'b0};
        vecs[6] = '{3, -8'sd100,   8'sd50,  -79, 1'b0};
        vecs[7] = '{1,   8'sd64,  8'sd127,  127, 1'b0};
        vecs[8] = '{2,   8'sd64, -8'sd128, -128, 1'b0};
        vecs[9] = '{1,   8'sd65,  8'sd127,  127, 1'b1};

        fa_a = '{64, 64, 127, -32};
        fa_b = '{10, -20, 127, 6};
        fa_d = '{10, -20, 127, -3};
        fa_s = '{0, 0, 1, 0};

        // Reset state.
        tick();
        tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_mult_a", int'(mult_a), 0);
        chk("rst_mult_b", int'(mult_b), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_ch", int'(res_ch), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_sat", int'(res_sat), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        en    = 1'b1;
        tick();

        // Table of single transactions: grant, latency, value, saturation.
        for (int v = 0; v < 10; v++) begin
            set_ops(vecs[v].ch, vecs[v].a, vecs[v].b);
            req = 4'(1 << vecs[v].ch);
            tick();
            chk("vec_grant", int'(grant), 1 << vecs[v].ch);
            chk("vec_mult_a", int'($signed(mult_a)), int'(vecs[v].a));
            req = '0;
            for (int k = 1; k <= 3; k++) begin
                tick();
                if (k < 3) begin
                    chk("vec_early_valid", int'(res_valid), 0);
                    chk("vec_busy", int'(busy), 1);
                end else begin
                    chk("vec_valid", int'(res_valid), 1);
                    chk("vec_ch", int'(res_ch), vecs[v].ch);
                    chk("vec_data", int'($signed(res_data)), vecs[v].exp_d);
                    chk("vec_sat", int'(res_sat), int'(vecs[v].exp_s));
                end
            end
            tick();
            chk("vec_valid_off", int'(res_valid), 0);
            chk("vec_sat_off", int'(res_sat), 0);
            chk("vec_data_hold", int'($signed(res_data)), vecs[v].exp_d);
            $display("vec %0d: ch%0d a=%0d b=%0d -> res_data=%0d res_sat=%0d",
                     v, vecs[v].ch, vecs[v].a, vecs[v].b, $signed(res_data), vecs[v].exp_s);
        end

        // Reset so the pointer restarts with channel 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Fairness: all channels requesting for 12 edges.
        for (int c = 0; c < 4; c++) begin
            set_ops(c, 8'(fa_a[c]), 8'(fa_b[c]));
        end
        req = 4'hf;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (t == 11) req = '0;
            chk("fair_grant", int'(grant), (t < 12) ? (1 << (t % 4)) : 0);
            chk("fair_valid", int'(res_valid), (t >= 3) ? 1 : 0);
            if (t >= 3) begin
                chk("fair_ch", int'(res_ch), (t - 3) % 4);
                chk("fair_data", int'($signed(res_data)), fa_d[(t - 3) % 4]);
                chk("fair_sat", int'(res_sat), fa_s[(t - 3) % 4]);
            end
            if (t == 13) chk("fair_busy_tail", int'(busy), 1);
            if (t == 14) chk("fair_busy_drained", int'(busy), 0);
        end
        $display("fairness: 12 grants rotated, 12 results returned");

        // Masking: ch1 holds req; grants land on alternate cycles.
        req = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("mask_grant", int'(grant), (t % 2 == 0) ? 2 : 0);
        end
        req = '0;
        for (int t = 0; t < 4; t++) tick();
        $display("masking: held req on ch1 granted every other cycle");

        // Reset while a product is in flight.
        req = 4'b1000;
        tick();
        chk("rmid_grant", int'(grant), 8);
        req = '0;
        tick();
        reset = 1'b1;
        #1;
        chk("rmid_grant0", int'(grant), 0);
        chk("rmid_mult_a", int'(mult_a), 0);
        chk("rmid_mult_b", int'(mult_b), 0);
        chk("rmid_valid0", int'(res_valid), 0);
        chk("rmid_ch0", int'(res_ch), 0);
        chk("rmid_data0", int'(res_data), 0);
        chk("rmid_sat0", int'(res_sat), 0);
        chk("rmid_busy0", int'(busy), 0);
        tick();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rmid_no_valid", int'(res_valid), 0);
        end
        req = 4'b1001;
        tick();
        chk("rmid_first", int'(grant), 1);
        tick();
        chk("rmid_second", int'(grant), 8);
        req = '0;
        for (int t = 0; t < 4; t++) tick();
        $display("reset mid-flight: in-flight product dropped, ch0 first after release");

        // Enable gating: in-flight results drain, then resume past pointer.
        req = 4'hf;
        tick();
        chk("en_grant_a", int'(grant), 1);
        tick();
        chk("en_grant_b", int'(grant), 2);
        en = 1'b0;
        tick();
        chk("en_off_grant0", int'(grant), 0);
        chk("en_off_busy0", int'(busy), 1);
        chk("en_off_valid0", int'(res_valid), 0);
        tick();
        chk("en_off_grant1", int'(grant), 0);
        chk("en_off_busy1", int'(busy), 1);
        chk("en_off_valid1", int'(res_valid), 1);
        chk("en_off_ch1", int'(res_ch), 0);
        chk("en_off_data1", int'($signed(res_data)), 10);
        tick();
        chk("en_off_busy2", int'(busy), 0);
        chk("en_off_valid2", int'(res_valid), 1);
        chk("en_off_ch2", int'(res_ch), 1);
        chk("en_off_data2", int'($signed(res_data)), -20);
        tick();
        chk("en_off_grant3", int'(grant), 0);
        chk("en_off_valid3", int'(res_valid), 0);
        chk("en_off_mult_a", int'($signed(mult_a)), 64);
        en = 1'b1;
        tick();
        chk("en_resume", int'(grant), 4);
        req = '0;
        for (int t = 0; t < 4; t++) tick();
        $display("enable gating: drained with en low, resumed at ch2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iir_mult_sched.md
Name: iir_mult_sched

Overview:
- Time-multiplexes one registered signed multiplier core between NUM_CH first-order IIR filter channels, e.g. I/Q high-pass stages running at the decimated ~33.2 kHz sample rate.
- Round-robin arbiter:
  - grants one channel per clk cycle;
  - drives the shared multiplier operands;
  - tracks in-flight products with a channel-tag pipeline;
  - returns each scaled, saturated product to its owner with a valid strobe.
- Sits between the per-channel filter datapaths and the multiplier instance.

Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- A_W, 8: signed width of operand A (coefficient).
- B_W, 8: signed width of operand B (feedback sample).
- MULT_LAT, 2: clk edges from operands registered at the multiplier input to product valid at its output (≥1).
- SHIFT, 6: arithmetic right shift applied to the product; 64 equals unity gain.
- OUT_W, 8: signed width of the returned result.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; when low, no new grants are issued and in-flight products still drain.
- req  in  NUM_CH  per-channel request level.
- a_flat  in  NUM_CH*A_W  per-channel operand A; channel k occupies bits [k*A_W +: A_W].
- b_flat  in  NUM_CH*B_W  per-channel operand B, same packing.
- grant  out  NUM_CH  one-hot, one-cycle grant pulse.
- mult_a  out  A_W  registered operand to the multiplier.
- mult_b  out  B_W  registered operand to the multiplier.
- mult_p  in  A_W+B_W  multiplier product.
- res_valid  out  1  result strobe, one cycle.
- res_ch  out  $clog2(NUM_CH)  channel owning res_data.
- res_data  out  OUT_W  scaled, saturated product.
- res_sat  out  1  high with res_valid when res_data was clipped.
- busy  out  1  high while any product is in flight.

Behaviour:
- Reset (async assert, released synchronously to clk): grant=0, mult_a=0, mult_b=0, res_valid=0, res_ch=0, res_data=0, res_sat=0, busy=0. The round-robin pointer resets so channel 0 has highest priority. All in-flight tags are cleared; products pending at reset are never reported.
- Arbitration at each edge with en=1:
  - Eligible set = req & ~grant. The channel currently granted is masked, so a requester holding req one cycle too long is not double-granted back to back.
  - Winner = first eligible channel scanning last+1, last+2, … modulo NUM_CH.
  - Registered outputs: grant[winner]=1, mult_a=a[winner], mult_b=b[winner]. The pointer updates to winner.
- No eligible channel, or en=0: grant=0; mult_a/mult_b hold their values; a bubble enters the tag pipeline.
- Requester rule: deassert req in the cycle grant is seen. A req still high two cycles after its grant is treated as a new request.
- Throughput: one grant per cycle maximum. With all channels requesting continuously (req never dropped), grants rotate 0,1,…,NUM_CH-1,0,…
- Tag pipeline:
  - Depth MULT_LAT+1, entry = {valid, ch}.
  - Grant edge E0 pushes {1,winner}. mult_p for that grant is valid after edge E0+MULT_LAT.
  - res_* are registered at edge E0+MULT_LAT+1. res_valid is therefore high in the cycle MULT_LAT+1 edges after the grant edge: grant-to-res_valid latency = MULT_LAT+1 cycles.
- Result arithmetic:
  - s = mult_p >>> SHIFT (arithmetic shift, floor toward −inf).
  - If s > 2^(OUT_W−1)−1: res_data = 2^(OUT_W−1)−1, res_sat=1.
  - If s < −2^(OUT_W−1): res_data = −2^(OUT_W−1), res_sat=1.
  - Otherwise res_data = s[OUT_W−1:0], res_sat=0.
- res_data/res_ch hold between strobes; res_sat clears when res_valid=0.
- busy = OR of tag-pipeline valid bits (registered view).
- en falling mid-burst: in-flight results all still appear. en rising resumes from the stored pointer.
- Simultaneous new request and own result return are independent; no stall exists. The multiplier is fully pipelined, so there is no backpressure.

Test Plan:
- Single request: reset, en=1, ch2 pulses req with a=64, b=−100 → grant[2] one cycle; res_valid exactly 3 cycles later (MULT_LAT=2), res_ch=2, res_data=−100, res_sat=0.
- Saturation: ch0 a=127, b=127 → product 16129, >>>6 = 252 → res_data=127, res_sat=1. Then a=−128, b=127 → −254 → res_data=−128, res_sat=1. Check floor rounding: a=1, b=−1 → res_data=−1.
- Fairness: all four req held high for 12 cycles → grant order 0,1,2,3,0,1,2,3,…; res_ch sequence identical, shifted 3 cycles, and each result matches its own operands.
- Masking: ch1 holds req for two cycles after grant → grant[1] never high in consecutive cycles; with only ch1 requesting, grants land on alternate cycles.
- Reset mid-flight: grant ch3 then assert reset one cycle later → all outputs zero immediately; no res_valid after release; next grant goes to ch0 when ch0 and ch3 both request.
- en gating: en=0 with req=4'b1111 → no grants, busy falls after in-flight drains. en=1 → arbitration resumes at the pointer+1 channel.
